// File: rtl/armleocpu_tlb.sv
`default_nettype none
// ============================================================================
// Module      : armleocpu_tlb
// Description : Fully-associative TLB in front of the Sv32 page table walker.
//               Hits are answered from the entry array. Misses issue a PTW
//               resolve request, and successful walks fill a round-robin
//               victim. Bare mode bypasses translation. The invalidate input
//               flushes every entry.
// Ports       : clk, async_rst_n            - clock, async active-low reset
//               req_*                       - VPN lookup request from the MMU
//               resp_*                      - registered one-cycle response
//               invalidate, matp_mode       - flush / translation mode
//               ptw_*                       - PTW resolve handshake
// Revision    : 1.0 - initial release
// ============================================================================
module armleocpu_tlb #(
    parameter int ENTRIES_W = 3
) (
    input  logic        clk,
    input  logic        async_rst_n,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic [19:0] req_vpn,

    output logic        resp_valid,
    output logic [21:0] resp_ppn,
    output logic [7:0]  resp_access_bits,
    output logic        resp_pagefault,
    output logic        resp_accessfault,

    input  logic        invalidate,
    input  logic        matp_mode,

    output logic        ptw_resolve_request,
    input  logic        ptw_resolve_ack,
    output logic [21:0] ptw_virtual_address,
    input  logic        ptw_resolve_done,
    input  logic        ptw_resolve_pagefault,
    input  logic        ptw_resolve_accessfault,
    input  logic [7:0]  ptw_resolve_access_bits,
    input  logic [21:0] ptw_resolve_physical_address
);

    localparam int c_ENTRIES = 1 << ENTRIES_W;

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_LOOKUP    = 2'd1;
    localparam logic [1:0] c_WALK_REQ  = 2'd2;
    localparam logic [1:0] c_WALK_WAIT = 2'd3;

    localparam logic [7:0] c_BARE_BITS = 8'hCF;

    logic [1:0]           r_state;
    logic [1:0]           w_next_state;
    logic [19:0]          r_saved_vpn;
    logic                 r_flushed;
    logic [ENTRIES_W-1:0] r_victim;

    logic [c_ENTRIES-1:0] r_valid;
    logic [19:0]          r_vpn  [c_ENTRIES];
    logic [21:0]          r_ppn  [c_ENTRIES];
    logic [7:0]           r_bits [c_ENTRIES];

    logic                 r_resp_valid;
    logic [21:0]          r_resp_ppn;
    logic [7:0]           r_resp_bits;
    logic                 r_resp_pagefault;
    logic                 r_resp_accessfault;

    logic                 w_hit;
    logic [ENTRIES_W-1:0] w_hit_idx;
    logic                 w_lookup_resp;
    logic                 w_walk_done;
    logic                 w_fill;

    // Tags are unique, so at most one entry matches.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = 0; i < c_ENTRIES; i++) begin
            if (r_valid[i] && (r_vpn[i] == r_saved_vpn)) begin
                w_hit     = 1'b1;
                w_hit_idx = ENTRIES_W'(i);
            end
        end
    end

    // A done coinciding with ack in WALK_REQ completes the walk immediately.
    assign w_walk_done = ((r_state == c_WALK_REQ) && ptw_resolve_ack && ptw_resolve_done)
                       || ((r_state == c_WALK_WAIT) && ptw_resolve_done);

    // Faults are never cached; any flush seen since LOOKUP suppresses the fill.
    assign w_fill = w_walk_done && !ptw_resolve_pagefault && !ptw_resolve_accessfault
                  && !r_flushed && !invalidate;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:      if (req_valid) w_next_state = c_LOOKUP;
            c_LOOKUP:    w_next_state = w_lookup_resp ? c_IDLE : c_WALK_REQ;
            c_WALK_REQ:  if (ptw_resolve_ack)
                             w_next_state = ptw_resolve_done ? c_IDLE : c_WALK_WAIT;
            c_WALK_WAIT: if (ptw_resolve_done) w_next_state = c_IDLE;
            default:     w_next_state = c_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        req_ready           = (r_state == c_IDLE);
        ptw_resolve_request = (r_state == c_WALK_REQ);
        // Invalidate in the LOOKUP cycle turns a would-be hit into a miss.
        w_lookup_resp       = (r_state == c_LOOKUP) && (!matp_mode || (w_hit && !invalidate));
    end

    assign ptw_virtual_address = {2'b00, r_saved_vpn};

    // ---------------- Request capture and flush tracking ----------------
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_saved_vpn <= '0;
            r_flushed   <= 1'b0;
        end else begin
            if ((r_state == c_IDLE) && req_valid) begin
                r_saved_vpn <= req_vpn;
            end
            if (r_state == c_LOOKUP) begin
                r_flushed <= invalidate;
            end else if ((r_state == c_WALK_REQ) || (r_state == c_WALK_WAIT)) begin
                r_flushed <= r_flushed | invalidate;
            end
        end
    end

    // ---------------- Valid bits and victim pointer ----------------
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_valid  <= '0;
            r_victim <= '0;
        end else begin
            if (invalidate) begin
                r_valid <= '0;
            end else if (w_fill) begin
                r_valid[r_victim] <= 1'b1;
            end
            if (w_fill) begin
                r_victim <= r_victim + 1'b1;
            end
        end
    end

    // ---------------- Entry payload (no reset needed, guarded by valid) ----------------
    generate
        for (genvar gi = 0; gi < c_ENTRIES; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (w_fill && (r_victim == ENTRIES_W'(gi))) begin
                    r_vpn[gi]  <= r_saved_vpn;
                    r_ppn[gi]  <= ptw_resolve_physical_address;
                    r_bits[gi] <= ptw_resolve_access_bits;
                end
            end
        end
    endgenerate

    // ---------------- Registered response ----------------
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_resp_valid       <= 1'b0;
            r_resp_ppn         <= '0;
            r_resp_bits        <= '0;
            r_resp_pagefault   <= 1'b0;
            r_resp_accessfault <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            if (w_lookup_resp) begin
                r_resp_valid       <= 1'b1;
                r_resp_pagefault   <= 1'b0;
                r_resp_accessfault <= 1'b0;
                if (!matp_mode) begin
                    r_resp_ppn  <= {2'b00, r_saved_vpn};
                    r_resp_bits <= c_BARE_BITS;
                end else begin
                    r_resp_ppn  <= r_ppn[w_hit_idx];
                    r_resp_bits <= r_bits[w_hit_idx];
                end
            end else if (w_walk_done) begin
                r_resp_valid       <= 1'b1;
                r_resp_ppn         <= ptw_resolve_physical_address;
                r_resp_bits        <= ptw_resolve_access_bits;
                r_resp_pagefault   <= ptw_resolve_pagefault;
                r_resp_accessfault <= ptw_resolve_accessfault;
            end
        end
    end

    assign resp_valid       = r_resp_valid;
    assign resp_ppn         = r_resp_ppn;
    assign resp_access_bits = r_resp_bits;
    assign resp_pagefault   = r_resp_pagefault;
    assign resp_accessfault = r_resp_accessfault;

endmodule
`default_nettype wire

// File: tb/tb_armleocpu_tlb.sv
`default_nettype none
// ============================================================================
// Module      : tb_armleocpu_tlb
// Description : Scoreboard bench for armleocpu_tlb. The driver acts as MMU
//               and PTW, predicts each response from a FIFO-of-fills cache
//               model and queues it; a monitor pops and compares on every
//               resp_valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_armleocpu_tlb;

    localparam int ENTRIES_W = 3;
    localparam int CAP       = 1 << ENTRIES_W;

    logic        clk;
    logic        async_rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [19:0] req_vpn;
    logic        resp_valid;
    logic [21:0] resp_ppn;
    logic [7:0]  resp_access_bits;
    logic        resp_pagefault;
    logic        resp_accessfault;
    logic        invalidate;
    logic        matp_mode;
    logic        ptw_resolve_request;
    logic        ptw_resolve_ack;
    logic [21:0] ptw_virtual_address;
    logic        ptw_resolve_done;
    logic        ptw_resolve_pagefault;
    logic        ptw_resolve_accessfault;
    logic [7:0]  ptw_resolve_access_bits;
    logic [21:0] ptw_resolve_physical_address;

    armleocpu_tlb #(.ENTRIES_W(ENTRIES_W)) dut (
        .clk                          (clk),
        .async_rst_n                  (async_rst_n),
        .req_valid                    (req_valid),
        .req_ready                    (req_ready),
        .req_vpn                      (req_vpn),
        .resp_valid                   (resp_valid),
        .resp_ppn                     (resp_ppn),
        .resp_access_bits             (resp_access_bits),
        .resp_pagefault               (resp_pagefault),
        .resp_accessfault             (resp_accessfault),
        .invalidate                   (invalidate),
        .matp_mode                    (matp_mode),
        .ptw_resolve_request          (ptw_resolve_request),
        .ptw_resolve_ack              (ptw_resolve_ack),
        .ptw_virtual_address          (ptw_virtual_address),
        .ptw_resolve_done             (ptw_resolve_done),
        .ptw_resolve_pagefault        (ptw_resolve_pagefault),
        .ptw_resolve_accessfault      (ptw_resolve_accessfault),
        .ptw_resolve_access_bits      (ptw_resolve_access_bits),
        .ptw_resolve_physical_address (ptw_resolve_physical_address)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [19:0] vpn;
        logic [21:0] ppn;
        logic [7:0]  bits;
    } ent_t;

    typedef struct {
        int          cyc;
        logic [21:0] ppn;
        logic [7:0]  bits;
        logic        pf;
        logic        af;
    } exp_t;

    // Cache model: the entries filled since the last flush, oldest first.
    ent_t model[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_find(input logic [19:0] vpn);
        foreach (model[i]) if (model[i].vpn == vpn) return i;
        return -1;
    endfunction

    task automatic model_fill(input logic [19:0] vpn, input logic [21:0] ppn, input logic [7:0] bits);
        ent_t e;
        e.vpn = vpn; e.ppn = ppn; e.bits = bits;
        model.push_back(e);
        if (model.size() > CAP) model.delete(0);
    endtask

    // Monitor: every response pulse must match the oldest queued expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (async_rst_n && resp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL resp_unexpected actual=resp_valid=1 ppn=%0h expected=no response", resp_ppn);
            end else begin
                e = sb.pop_front();
                chk("resp_cycle", cyc, e.cyc);
                chk("resp_ppn", resp_ppn, e.ppn);
                chk("resp_bits", resp_access_bits, e.bits);
                chk("resp_pagefault", resp_pagefault, e.pf);
                chk("resp_accessfault", resp_accessfault, e.af);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_flush();
        invalidate = 1'b1;
        model.delete();
        tick();
        invalidate = 1'b0;
    endtask

    // One lookup. inv_at: 0 none, 1 with accept, 2 in LOOKUP, 3 in walk, 4 with done.
    task automatic do_txn(input logic [19:0] vpn, input logic mode, input int inv_at,
                          input int ack_dly, input int done_dly, input bit co,
                          input logic [21:0] ppn, input logic [7:0] bits,
                          input logic pf, input logic af);
        int   idx;
        int   t;
        bit   quick;
        exp_t e;
        t = 0;
        while (!req_ready && t < 100) begin
            tick();
            t++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL req_ready_timeout actual=0 expected=1");
            return;
        end
        req_valid  = 1'b1;
        req_vpn    = vpn;
        matp_mode  = mode;
        invalidate = (inv_at == 1);
        if (inv_at == 1) model.delete();
        idx   = model_find(vpn);
        quick = (mode == 1'b0) || (idx >= 0 && inv_at != 2);
        if (quick) begin
            e.cyc = cyc + 2;
            if (mode == 1'b0) begin
                e.ppn  = {2'b00, vpn};
                e.bits = 8'hCF;
            end else begin
                e.ppn  = model[idx].ppn;
                e.bits = model[idx].bits;
            end
            e.pf = 1'b0;
            e.af = 1'b0;
            sb.push_back(e);
        end
        tick();
        req_valid  = 1'b0;
        invalidate = (inv_at == 2);
        if (inv_at == 2) model.delete();
        tick();
        invalidate = 1'b0;
        if (quick) begin
            chk("hit_req_ready", req_ready, 1);
            chk("hit_no_walk", ptw_resolve_request, 0);
            return;
        end
        chk("walk_request", ptw_resolve_request, 1);
        chk("walk_vaddr", ptw_virtual_address, {2'b00, vpn});
        repeat (ack_dly) tick();
        chk("walk_request_held", ptw_resolve_request, 1);
        chk("walk_vaddr_held", ptw_virtual_address, {2'b00, vpn});
        ptw_resolve_ack = 1'b1;
        if (!co) begin
            tick();
            ptw_resolve_ack = 1'b0;
            chk("ack_drops_request", ptw_resolve_request, 0);
            invalidate = (inv_at == 3);
            if (inv_at == 3) model.delete();
            tick();
            invalidate = 1'b0;
            repeat (done_dly) tick();
        end
        ptw_resolve_done             = 1'b1;
        ptw_resolve_physical_address = ppn;
        ptw_resolve_access_bits      = bits;
        ptw_resolve_pagefault        = pf;
        ptw_resolve_accessfault      = af;
        invalidate = (inv_at == 4) || (inv_at == 3 && co);
        if (invalidate) model.delete();
        e.cyc = cyc + 1; e.ppn = ppn; e.bits = bits; e.pf = pf; e.af = af;
        sb.push_back(e);
        tick();
        ptw_resolve_ack         = 1'b0;
        ptw_resolve_done        = 1'b0;
        ptw_resolve_pagefault   = 1'b0;
        ptw_resolve_accessfault = 1'b0;
        invalidate              = 1'b0;
        if (inv_at < 2 && !pf && !af) model_fill(vpn, ppn, bits);
    endtask

    task automatic simple(input logic [19:0] vpn, input int inv_at);
        do_txn(vpn, 1'b1, inv_at, 1, 0, 1'b0, 22'($urandom), 8'($urandom), 1'b0, 1'b0);
    endtask

    initial begin : watchdog
        #1000000;
        failures++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin : main
        async_rst_n = 1'b0;
        req_valid = 1'b0; req_vpn = '0; invalidate = 1'b0; matp_mode = 1'b1;
        ptw_resolve_ack = 1'b0; ptw_resolve_done = 1'b0;
        ptw_resolve_pagefault = 1'b0; ptw_resolve_accessfault = 1'b0;
        ptw_resolve_access_bits = '0; ptw_resolve_physical_address = '0;
        #1;
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_ppn", resp_ppn, 0);
        chk("rst_resp_bits", resp_access_bits, 0);
        chk("rst_resp_faults", {resp_pagefault, resp_accessfault}, 0);
        chk("rst_ptw_request", ptw_resolve_request, 0);
        repeat (3) @(posedge clk);
        #3 async_rst_n = 1'b1;
        tick();
        chk("rst_req_ready", req_ready, 1);

        // Bare-mode bypass
        do_txn(20'h12345, 1'b0, 0, 0, 0, 1'b0, '0, '0, 1'b0, 1'b0);
        // Sv32 miss then hit
        do_txn(20'h00ABC, 1'b1, 0, 3, 0, 1'b0, 22'h3FFFFF, 8'hCF, 1'b0, 1'b0);
        do_txn(20'h00ABC, 1'b1, 0, 0, 0, 1'b0, '0, '0, 1'b0, 1'b0);
        // Faults are never cached
        do_txn(20'h70001, 1'b1, 0, 1, 1, 1'b0, 22'h000111, 8'h00, 1'b1, 1'b0);
        do_txn(20'h70001, 1'b1, 0, 0, 0, 1'b1, 22'h000222, 8'h01, 1'b1, 1'b0);
        do_txn(20'h70001, 1'b1, 0, 2, 0, 1'b0, 22'h000333, 8'h03, 1'b0, 1'b1);

        // Replacement wrap: 9 fills into 8 entries evicts the first
        idle_flush();
        for (int i = 0; i < 9; i++) simple(20'h50000 + 20'(i), 0);
        for (int i = 1; i < 9; i++) simple(20'h50000 + 20'(i), 0);
        simple(20'h50000, 0);

        // Invalidate cases
        simple(20'h60001, 3);
        simple(20'h60001, 0);
        simple(20'h60001, 2);
        simple(20'h60001, 0);
        simple(20'h60002, 4);
        simple(20'h60002, 0);
        simple(20'h60001, 0);
        idle_flush();
        simple(20'h60001, 0);
        simple(20'h60002, 0);

        // Randomized traffic over a pool larger than the TLB
        for (int n = 0; n < 300; n++) begin
            int r;
            int inv_at;
            r = int'($urandom % 20);
            inv_at = (r < 4) ? r + 1 : 0;
            r = int'($urandom % 8);
            if ($urandom % 6 == 0) repeat ($urandom_range(1, 3)) tick();
            if ($urandom % 40 == 0) idle_flush();
            do_txn(20'h40000 + 20'($urandom_range(0, 11)),
                   ($urandom % 10) != 0, inv_at,
                   $urandom_range(0, 3), $urandom_range(0, 2), ($urandom % 4) == 0,
                   22'($urandom), 8'($urandom), r == 0, r == 1);
        end

        // Reset mid-walk: request must drop without a clock edge
        simple(20'h00777, 0);
        simple(20'h00777, 0);
        while (!req_ready) tick();
        req_valid = 1'b1; req_vpn = 20'h00888; matp_mode = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        chk("rstwalk_request_before", ptw_resolve_request, 1);
        #2 async_rst_n = 1'b0;
        #1;
        chk("rstwalk_request_async", ptw_resolve_request, 0);
        chk("rstwalk_resp_valid", resp_valid, 0);
        chk("rstwalk_resp_ppn", resp_ppn, 0);
        model.delete();
        sb.delete();
        @(posedge clk);
        #3 async_rst_n = 1'b1;
        tick();
        chk("rstwalk_req_ready", req_ready, 1);
        simple(20'h00777, 0);

        // Reset during a response pulse clears it immediately
        req_valid = 1'b1; req_vpn = 20'h0ABCD; matp_mode = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        chk("rstpulse_resp_valid_before", resp_valid, 1);
        async_rst_n = 1'b0;
        #1;
        chk("rstpulse_resp_valid_async", resp_valid, 0);
        model.delete();
        @(posedge clk);
        #3 async_rst_n = 1'b1;
        matp_mode = 1'b1;
        tick();
        simple(20'h00777, 0);

        repeat (5) tick();
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
